// File: rtl/pp_carry_accum_sreg_pkg.sv
// Shared state type and sizing helpers for the Booth partial-product accumulator.
package pp_carry_accum_sreg_pkg;

    localparam int ACC_RADIX_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_ACCUM,
        ACC_DONE
    } acc_state_e;

    function automatic int nsteps(input int w, input int r);
        return w / r;
    endfunction

    function automatic int cnt_w(input int w, input int r);
        return $clog2(nsteps(w, r) + 1);
    endfunction

endpackage

// File: rtl/pp_carry_accum_sreg.sv
// Carry-save accumulator for the radix-2^R Booth multiplier: each accepted step
// shifts sum/carry right by R bits and inserts a new CSA slice on top.
//
// state     | meaning
// ----------|----------------------------------------------------
// ACC_IDLE  | waiting for start; registers hold last contents
// ACC_ACCUM | accepting slices, in_ready=1, step_idx counts steps
// ACC_DONE  | result pair presented, out_valid=1 until consumed
module pp_carry_accum_sreg
    import pp_carry_accum_sreg_pkg::*;
#(
    parameter int  WIDTH      = 32,
    parameter int  RADIX_LOG2 = ACC_RADIX_LOG2_DEF,
    parameter bit  SIGN_EXT   = 1'b1,
    localparam int NSTEPS     = nsteps(WIDTH, RADIX_LOG2),
    localparam int DIN_W      = WIDTH + RADIX_LOG2 - 1,
    localparam int CNT_W      = cnt_w(WIDTH, RADIX_LOG2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIN_W-1:0]     pp_din,
    input  logic [DIN_W-1:0]     carry_din,
    output logic [WIDTH-1:0]     pp_hi,
    output logic [WIDTH-1:0]     carry_hi,
    output logic [CNT_W-1:0]     step_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   res_pp,
    output logic [2*WIDTH-1:0]   res_carry
);

    if (WIDTH % RADIX_LOG2 != 0) begin : g_bad_width
        $error("pp_carry_accum_sreg: WIDTH must be a multiple of RADIX_LOG2");
    end

    localparam logic [CNT_W-1:0] NSTEPS_C = CNT_W'(NSTEPS);

    acc_state_e           state_q, state_d;
    logic [2*WIDTH-1:0]   acc_pp_q, acc_pp_d;
    logic [2*WIDTH-1:0]   acc_carry_q, acc_carry_d;
    logic [CNT_W-1:0]     step_idx_q, step_idx_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic                 step;
    logic                 ext_bit;
    logic [CNT_W-1:0]     step_inc;

    always_comb begin
        state_d     = state_q;
        acc_pp_d    = acc_pp_q;
        acc_carry_d = acc_carry_q;
        step_idx_d  = step_idx_q;
        step        = in_valid && in_ready_q;
        ext_bit     = SIGN_EXT ? pp_din[DIN_W-1] : 1'b0;
        step_inc    = (step_idx_q < NSTEPS_C) ? step_idx_q + CNT_W'(1) : NSTEPS_C;

        // start wins in every state, including a simultaneous slice or result handoff
        if (start) begin
            state_d     = ACC_ACCUM;
            acc_pp_d    = '0;
            acc_carry_d = '0;
            step_idx_d  = '0;
        end else begin
            unique case (state_q)
                ACC_IDLE: ;
                ACC_ACCUM: begin
                    if (step) begin
                        acc_pp_d    = {ext_bit, pp_din, acc_pp_q[WIDTH-1:RADIX_LOG2]};
                        acc_carry_d = {carry_din, 1'b0, acc_carry_q[WIDTH-1:RADIX_LOG2]};
                        step_idx_d  = step_inc;
                        if (step_inc == NSTEPS_C) begin
                            state_d = ACC_DONE;
                        end
                    end
                end
                ACC_DONE: begin
                    if (out_ready) begin
                        state_d = ACC_IDLE;
                    end
                end
                default: state_d = ACC_IDLE;
            endcase
        end

        in_ready_d  = (state_d == ACC_ACCUM);
        out_valid_d = (state_d == ACC_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACC_IDLE;
            acc_pp_q    <= '0;
            acc_carry_q <= '0;
            step_idx_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_pp_q    <= acc_pp_d;
            acc_carry_q <= acc_carry_d;
            step_idx_q  <= step_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign step_idx  = step_idx_q;
    assign pp_hi     = acc_pp_q[2*WIDTH-1:WIDTH];
    assign carry_hi  = acc_carry_q[2*WIDTH-1:WIDTH];
    assign res_pp    = acc_pp_q;
    assign res_carry = acc_carry_q;

endmodule

// File: tb/tb_pp_carry_accum_sreg.sv
// Bench for pp_carry_accum_sreg: two 8-bit instances (sign/zero extension) and a 32-bit instance.
module tb_pp_carry_accum_sreg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start8, valid8, oready8;
    logic [10:0] pp8, cy8;
    logic        rdy_s, rdy_z, ov_s, ov_z;
    logic [7:0]  pphi_s, cyhi_s, pphi_z, cyhi_z;
    logic [1:0]  idx_s, idx_z;
    logic [15:0] rpp_s, rcy_s, rpp_z, rcy_z;

    logic        start32, valid32, oready32;
    logic [34:0] pp32, cy32;
    logic        rdy32, ov32;
    logic [31:0] pphi32, cyhi32;
    logic [3:0]  idx32;
    logic [63:0] rpp32, rcy32;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_s, m_z, m_c;
    logic [63:0] m32_pp, m32_cy;

    pp_carry_accum_sreg #(.WIDTH(8), .RADIX_LOG2(4), .SIGN_EXT(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(valid8), .in_ready(rdy_s),
        .pp_din(pp8), .carry_din(cy8), .pp_hi(pphi_s), .carry_hi(cyhi_s), .step_idx(idx_s),
        .out_valid(ov_s), .out_ready(oready8), .res_pp(rpp_s), .res_carry(rcy_s));

    pp_carry_accum_sreg #(.WIDTH(8), .RADIX_LOG2(4), .SIGN_EXT(1'b0)) u_z (
        .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(valid8), .in_ready(rdy_z),
        .pp_din(pp8), .carry_din(cy8), .pp_hi(pphi_z), .carry_hi(cyhi_z), .step_idx(idx_z),
        .out_valid(ov_z), .out_ready(oready8), .res_pp(rpp_z), .res_carry(rcy_z));

    pp_carry_accum_sreg #(.WIDTH(32), .RADIX_LOG2(4), .SIGN_EXT(1'b1)) u_32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .in_valid(valid32), .in_ready(rdy32),
        .pp_din(pp32), .carry_din(cy32), .pp_hi(pphi32), .carry_hi(cyhi32), .step_idx(idx32),
        .out_valid(ov32), .out_ready(oready32), .res_pp(rpp32), .res_carry(rcy32));

    // Reference: the accumulator as a 2W-bit number; each step keeps the low half
    // divided by 2^R and adds the extended slice weighted by 2^(W-R).
    function automatic logic [127:0] ref_pp(input logic [127:0] acc, input logic [127:0] din,
                                            input int w, input int r, input bit se);
        logic [127:0] slice;
        slice = din;
        if (se && din[w + r - 2]) slice = din + (128'd1 << (w + r - 1));
        return ((slice << (w - r)) + ((acc % (128'd1 << w)) >> r)) % (128'd1 << (2 * w));
    endfunction

    function automatic logic [127:0] ref_cy(input logic [127:0] acc, input logic [127:0] din,
                                            input int w, input int r);
        return ((din << (w - r + 1)) + ((acc % (128'd1 << w)) >> r)) % (128'd1 << (2 * w));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear8();
        m_s = '0; m_z = '0; m_c = '0;
    endtask

    task automatic start8_cycle();
        start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        clear8();
    endtask

    task automatic step8(input logic [10:0] p, input logic [10:0] c);
        valid8 = 1'b1; pp8 = p; cy8 = c;
        cyc();
        valid8 = 1'b0;
        m_s = 16'(ref_pp(128'(m_s), 128'(p), 8, 4, 1'b1));
        m_z = 16'(ref_pp(128'(m_z), 128'(p), 8, 4, 1'b0));
        m_c = 16'(ref_cy(128'(m_c), 128'(c), 8, 4));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start8 = 1'b1; valid8 = 1'b1; oready8 = 1'b0;
        start32 = 1'b1; valid32 = 1'b1; oready32 = 1'b0;
        pp8 = 11'h7FF; cy8 = 11'h7FF; pp32 = '1; cy32 = '1;
        cyc(); cyc();
        checks++; if (rdy_s !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", rdy_s); end
        checks++; if (ov_s !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov_s); end
        checks++; if (idx_s !== 2'd0) begin failures++; $display("FAIL reset_step_idx got=%0d exp=0", idx_s); end
        checks++; if (rpp_s !== 16'h0 || rcy_s !== 16'h0) begin failures++; $display("FAIL reset_res got=%h/%h exp=0/0", rpp_s, rcy_s); end
        checks++; if (rdy32 !== 1'b0 || ov32 !== 1'b0 || rpp32 !== 64'h0) begin failures++; $display("FAIL reset_32 got rdy=%b ov=%b pp=%h exp 0", rdy32, ov32, rpp32); end
        start8 = 1'b0; valid8 = 1'b0; start32 = 1'b0; valid32 = 1'b0;
        rst_n = 1'b1;
        cyc();
        checks++; if (rdy_s !== 1'b0) begin failures++; $display("FAIL reset_idle_after got=%b exp=0", rdy_s); end
        clear8();
    endtask

    task automatic test_basic();
        start8_cycle();
        checks++; if (rdy_s !== 1'b1 || rdy_z !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b%b exp=11", rdy_s, rdy_z); end
        valid8 = 1'b1;
        step8(11'h0A5, 11'h001);
        checks++; if (pphi_s !== 8'h0A || pphi_z !== 8'h0A) begin failures++; $display("FAIL basic_pp_hi got=%h/%h exp=0a", pphi_s, pphi_z); end
        checks++; if (cyhi_s !== 8'h00) begin failures++; $display("FAIL basic_carry_hi got=%h exp=00", cyhi_s); end
        checks++; if (idx_s !== 2'd1 || ov_s !== 1'b0) begin failures++; $display("FAIL basic_step1 got idx=%0d ov=%b exp idx=1 ov=0", idx_s, ov_s); end
        step8(11'h7FF, 11'h000);
        checks++; if (ov_s !== 1'b1 || ov_z !== 1'b1) begin failures++; $display("FAIL basic_latency_out_valid got=%b%b exp=11", ov_s, ov_z); end
        checks++; if (rpp_s !== 16'hFFF5) begin failures++; $display("FAIL basic_res_pp_sext got=%h exp=fff5", rpp_s); end
        checks++; if (rpp_z !== 16'h7FF5) begin failures++; $display("FAIL basic_res_pp_zext got=%h exp=7ff5", rpp_z); end
        checks++; if (rcy_s !== 16'h0002 || rcy_z !== 16'h0002) begin failures++; $display("FAIL basic_res_carry got=%h/%h exp=0002", rcy_s, rcy_z); end
        checks++; if (rdy_s !== 1'b0 || idx_s !== 2'd2) begin failures++; $display("FAIL basic_done got rdy=%b idx=%0d exp rdy=0 idx=2", rdy_s, idx_s); end
        oready8 = 1'b1;
        cyc();
        oready8 = 1'b0;
        checks++; if (ov_s !== 1'b0 || rdy_s !== 1'b0) begin failures++; $display("FAIL basic_consume got ov=%b rdy=%b exp 0 0", ov_s, rdy_s); end
    endtask

    task automatic test_bubbles();
        start8_cycle();
        step8(11'($urandom), 11'($urandom));
        for (int i = 0; i < 3; i++) begin
            pp8 = 11'($urandom); cy8 = 11'($urandom);
            cyc();
            checks++; if (idx_s !== 2'd1 || ov_s !== 1'b0 || rpp_s !== m_s || rcy_s !== m_c) begin
                failures++; $display("FAIL bubble_hold got idx=%0d ov=%b pp=%h cy=%h exp idx=1 ov=0 pp=%h cy=%h", idx_s, ov_s, rpp_s, rcy_s, m_s, m_c);
            end
        end
        step8(11'($urandom), 11'($urandom));
        checks++; if (ov_s !== 1'b1 || rpp_s !== m_s || rpp_z !== m_z || rcy_s !== m_c) begin
            failures++; $display("FAIL bubble_result got ov=%b pp=%h/%h cy=%h exp ov=1 pp=%h/%h cy=%h", ov_s, rpp_s, rpp_z, rcy_s, m_s, m_z, m_c);
        end
    endtask

    task automatic test_backpressure();
        oready8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid8 = 1'($urandom); pp8 = 11'($urandom); cy8 = 11'($urandom);
            cyc();
            checks++; if (ov_s !== 1'b1 || rdy_s !== 1'b0 || rpp_s !== m_s || rpp_z !== m_z || rcy_s !== m_c) begin
                failures++; $display("FAIL backpressure_hold got ov=%b rdy=%b pp=%h cy=%h exp ov=1 rdy=0 pp=%h cy=%h", ov_s, rdy_s, rpp_s, rcy_s, m_s, m_c);
            end
        end
        valid8 = 1'b0; oready8 = 1'b1;
        cyc();
        oready8 = 1'b0;
        checks++; if (ov_s !== 1'b0) begin failures++; $display("FAIL backpressure_release got=%b exp=0", ov_s); end
    endtask

    task automatic test_abort();
        start8_cycle();
        step8(11'($urandom), 11'($urandom));
        start8 = 1'b1; valid8 = 1'b1; pp8 = 11'($urandom); cy8 = 11'($urandom);
        cyc();
        start8 = 1'b0; valid8 = 1'b0;
        clear8();
        checks++; if (idx_s !== 2'd0 || rpp_s !== 16'h0 || rcy_s !== 16'h0 || rdy_s !== 1'b1) begin
            failures++; $display("FAIL abort_clear got idx=%0d pp=%h cy=%h rdy=%b exp 0 0 0 1", idx_s, rpp_s, rcy_s, rdy_s);
        end
        step8(11'($urandom), 11'($urandom));
        step8(11'($urandom), 11'($urandom));
        checks++; if (ov_s !== 1'b1 || rpp_s !== m_s || rcy_s !== m_c) begin
            failures++; $display("FAIL abort_restart got ov=%b pp=%h cy=%h exp ov=1 pp=%h cy=%h", ov_s, rpp_s, rcy_s, m_s, m_c);
        end
    endtask

    task automatic test_done_start();
        // in DONE from the previous test; restart without consuming
        oready8 = 1'b0;
        start8_cycle();
        checks++; if (ov_s !== 1'b0 || rdy_s !== 1'b1 || idx_s !== 2'd0 || rpp_s !== 16'h0) begin
            failures++; $display("FAIL done_start_noready got ov=%b rdy=%b idx=%0d pp=%h exp 0 1 0 0", ov_s, rdy_s, idx_s, rpp_s);
        end
        step8(11'($urandom), 11'($urandom));
        step8(11'($urandom), 11'($urandom));
        oready8 = 1'b1;
        start8_cycle();
        oready8 = 1'b0;
        checks++; if (ov_s !== 1'b0 || rdy_s !== 1'b1 || rcy_s !== 16'h0) begin
            failures++; $display("FAIL done_start_ready got ov=%b rdy=%b cy=%h exp 0 1 0", ov_s, rdy_s, rcy_s);
        end
        step8(11'($urandom), 11'($urandom));
        step8(11'($urandom), 11'($urandom));
        oready8 = 1'b1;
        cyc();
        oready8 = 1'b0;
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 3; i++) begin
            valid8 = 1'b1; pp8 = 11'($urandom); cy8 = 11'($urandom); oready8 = 1'($urandom);
            cyc();
            checks++; if (rdy_s !== 1'b0 || ov_s !== 1'b0 || idx_s !== 2'd2 || rpp_s !== m_s || rcy_s !== m_c) begin
                failures++; $display("FAIL idle_ignore got rdy=%b ov=%b idx=%0d pp=%h exp 0 0 2 %h", rdy_s, ov_s, idx_s, rpp_s, m_s);
            end
        end
        valid8 = 1'b0; oready8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        start8_cycle();
        step8(11'($urandom) | 11'h400, 11'($urandom) | 11'h001);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        clear8();
        checks++; if (rdy_s !== 1'b0 || ov_s !== 1'b0 || idx_s !== 2'd0 || pphi_s !== 8'h0 || cyhi_s !== 8'h0 || rpp_s !== 16'h0 || rcy_s !== 16'h0) begin
            failures++; $display("FAIL reset_mid got rdy=%b ov=%b idx=%0d pp=%h cy=%h exp all 0", rdy_s, ov_s, idx_s, rpp_s, rcy_s);
        end
        for (int i = 0; i < 2; i++) begin
            valid8 = 1'b1; pp8 = 11'($urandom);
            cyc();
            checks++; if (rdy_s !== 1'b0 || rpp_s !== 16'h0) begin failures++; $display("FAIL reset_mid_needs_start got rdy=%b pp=%h exp 0 0", rdy_s, rpp_s); end
        end
        valid8 = 1'b0;
        start8_cycle();
        checks++; if (rdy_s !== 1'b1) begin failures++; $display("FAIL reset_mid_resume got=%b exp=1", rdy_s); end
    endtask

    task automatic test_regression32();
        int bad = 0;
        for (int n = 0; n < 1000; n++) begin
            start32 = 1'b1;
            cyc();
            start32 = 1'b0;
            m32_pp = '0; m32_cy = '0;
            for (int k = 0; k < 8; k++) begin
                for (int b = $urandom_range(0, 2); b > 0; b--) begin
                    pp32 = 35'({$urandom(), $urandom()});
                    cyc();
                end
                valid32 = 1'b1;
                pp32 = 35'({$urandom(), $urandom()});
                cy32 = 35'({$urandom(), $urandom()});
                cyc();
                valid32 = 1'b0;
                m32_pp = 64'(ref_pp(128'(m32_pp), 128'(pp32), 32, 4, 1'b1));
                m32_cy = 64'(ref_cy(128'(m32_cy), 128'(cy32), 32, 4));
                checks++; if (idx32 !== 4'(k + 1) || pphi32 !== m32_pp[63:32] || cyhi32 !== m32_cy[63:32]) begin
                    failures++; bad++;
                    if (bad < 10) $display("FAIL reg32_step n=%0d k=%0d got idx=%0d pphi=%h cyhi=%h exp idx=%0d pphi=%h cyhi=%h", n, k, idx32, pphi32, cyhi32, k + 1, m32_pp[63:32], m32_cy[63:32]);
                end
            end
            for (int b = $urandom_range(0, 2); b >= 0; b--) begin
                checks++; if (ov32 !== 1'b1 || rpp32 !== m32_pp || rcy32 !== m32_cy) begin
                    failures++; bad++;
                    if (bad < 10) $display("FAIL reg32_result n=%0d got ov=%b pp=%h cy=%h exp ov=1 pp=%h cy=%h", n, ov32, rpp32, rcy32, m32_pp, m32_cy);
                end
                if (b > 0) cyc();
            end
            oready32 = 1'b1;
            cyc();
            oready32 = 1'b0;
            checks++; if (ov32 !== 1'b0 || rdy32 !== 1'b0) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL reg32_consume n=%0d got ov=%b rdy=%b exp 0 0", n, ov32, rdy32);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; valid8 = 1'b0; oready8 = 1'b0; pp8 = '0; cy8 = '0;
        start32 = 1'b0; valid32 = 1'b0; oready32 = 1'b0; pp32 = '0; cy32 = '0;
        clear8();
        m32_pp = '0; m32_cy = '0;
        test_reset();
        test_basic();
        test_bubbles();
        test_backpressure();
        test_abort();
        test_done_start();
        test_idle_ignore();
        test_reset_mid();
        test_regression32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
